// File: rtl/systolic_feeder.sv
// ---------------------------------------------------------------------------
// systolic_feeder
//
// Feeds the west (A) and north (B) edges of an N x N systolic MAC array.
// The host fills two N x N element buffers through a simple write port while
// the block is idle. A start pulse then streams 3N-2 skewed steps. At step t:
//   - A lane i carries A[i][t-i] for i <= t < i+N.
//   - B lane j carries B[t-j][j] for j <= t < j+N.
// As a result, PE(i,j) sees A[i][k] and B[k][j] on the same cycle.
// After the last step a single DONE cycle pulses `done`.
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   synchronous, active-high; clears state, outputs and buffers
//   wr_en    in   buffer write strobe (honoured in IDLE only)
//   wr_sel   in   0 = A buffer, 1 = B buffer
//   wr_row   in   row index of the write
//   wr_col   in   column index of the write
//   wr_data  in   element value
//   start    in   begin a stream
//   busy     out  high while a stream step is on the outputs
//   done     out  one-cycle pulse after the last stream step
//   a_data   out  N lanes of WIDTH bits; lane i feeds array row i
//   a_valid  out  per-lane qualifier for a_data
//   b_data   out  N lanes of WIDTH bits; lane j feeds array column j
//   b_valid  out  per-lane qualifier for b_data
// ---------------------------------------------------------------------------
module systolic_feeder #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  localparam int IW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic                 wr_sel,
  input  logic [IW-1:0]        wr_row,
  input  logic [IW-1:0]        wr_col,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [N*WIDTH-1:0]   a_data,
  output logic [N-1:0]         a_valid,
  output logic [N*WIDTH-1:0]   b_data,
  output logic [N-1:0]         b_valid
);

  // The step counter must hold values up to 3N-3.
  localparam int CW = $clog2(3*N - 1) > 0 ? $clog2(3*N - 1) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(3*N - 3);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] step_q, step_d;

  // stream_d: the step in step_d is presented on the outputs after this edge.
  logic stream_d;

  logic busy_q, busy_d;
  logic done_q, done_d;
  logic [N*WIDTH-1:0] a_data_q, a_data_d;
  logic [N*WIDTH-1:0] b_data_q, b_data_d;
  logic [N-1:0]       a_valid_q, a_valid_d;
  logic [N-1:0]       b_valid_q, b_valid_d;

  // Element buffers: [row][col].
  logic [WIDTH-1:0] a_mem_q [N][N];
  logic [WIDTH-1:0] b_mem_q [N][N];

  // -------------------------------------------------------------------------
  // Load port. Writes land only in IDLE, only when no start is taken on the
  // same edge, and only for in-range indices. This keeps the buffers frozen
  // for the whole stream.
  // -------------------------------------------------------------------------
  logic wr_accept;
  assign wr_accept = (state_q == ST_IDLE) && wr_en && !start &&
                     (int'(wr_row) < N) && (int'(wr_col) < N);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          a_mem_q[r][c] <= '0;
          b_mem_q[r][c] <= '0;
        end
      end
    end else if (wr_accept) begin
      if (wr_sel) begin
        b_mem_q[wr_row][wr_col] <= wr_data;
      end else begin
        a_mem_q[wr_row][wr_col] <= wr_data;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Sequencer. Outputs are registered, so the next-state logic computes
  // the step that appears after the coming edge and builds lane data for
  // that step.
  // A new start is accepted on the edge that closes the DONE cycle. This
  // lets back-to-back streams run with a single DONE cycle between them.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    stream_d = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_STREAM;
          step_d   = '0;
          stream_d = 1'b1;
        end
      end
      ST_STREAM: begin
        if (step_q == LAST_STEP) begin
          state_d = ST_DONE;
          step_d  = '0;
          done_d  = 1'b1;
        end else begin
          step_d   = step_q + 1'b1;
          stream_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_d  = ST_STREAM;
          step_d   = '0;
          stream_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        step_d  = '0;
      end
    endcase
    busy_d = stream_d;
  end

  // -------------------------------------------------------------------------
  // Per-lane skew. Lane g is active in the window g <= step < g+N. Inside
  // that window, (step - g) is the position along the row (A) or column (B).
  // -------------------------------------------------------------------------
  logic [N-1:0]  a_win, b_win;
  logic [IW-1:0] a_idx [N];
  logic [IW-1:0] b_idx [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    assign a_win[gi] = stream_d && (step_d >= CW'(gi)) && (step_d < CW'(gi + N));
    assign b_win[gi] = a_win[gi];
    assign a_idx[gi] = IW'(step_d - CW'(gi));
    assign b_idx[gi] = IW'(step_d - CW'(gi));

    assign a_valid_d[gi] = a_win[gi];
    assign b_valid_d[gi] = b_win[gi];
    assign a_data_d[gi*WIDTH +: WIDTH] = a_win[gi] ? a_mem_q[gi][a_idx[gi]] : '0;
    assign b_data_d[gi*WIDTH +: WIDTH] = b_win[gi] ? b_mem_q[b_idx[gi]][gi] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      step_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      a_data_q  <= '0;
      a_valid_q <= '0;
      b_data_q  <= '0;
      b_valid_q <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      a_data_q  <= a_data_d;
      a_valid_q <= a_valid_d;
      b_data_q  <= b_data_d;
      b_valid_q <= b_valid_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign a_data  = a_data_q;
  assign a_valid = a_valid_q;
  assign b_data  = b_data_q;
  assign b_valid = b_valid_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// ---------------------------------------------------------------------------
// tb_systolic_feeder
//
// Self-checking bench for systolic_feeder (N=4, WIDTH=8).
//
// The reference model holds the two matrices and the stream position.
// Expected lane contents are derived from the skew rule with matrix
// indexing:
//   - A lane i shows A[i][t-i] when i <= t < i+N.
//   - B lane j shows B[t-j][j] when j <= t < j+N.
//
// A compare process checks every DUT output on each falling edge. Directed
// literal checks pin the model at selected steps. A long randomized phase
// then exercises writes, starts and resets.
// ---------------------------------------------------------------------------
module tb_systolic_feeder;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;
  localparam int NSTEPS = 3*N - 2;

  logic             clk;
  logic             reset;
  logic             wr_en;
  logic             wr_sel;
  logic [IW-1:0]    wr_row;
  logic [IW-1:0]    wr_col;
  logic [W-1:0]     wr_data;
  logic             start;
  logic             busy;
  logic             done;
  logic [N*W-1:0]   a_data;
  logic [N-1:0]     a_valid;
  logic [N*W-1:0]   b_data;
  logic [N-1:0]     b_valid;

  systolic_feeder #(.WIDTH(W), .N(N)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_sel  (wr_sel),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_data (wr_data),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .a_data  (a_data),
    .a_valid (a_valid),
    .b_data  (b_data),
    .b_valid (b_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 streaming step mt, 2 done cycle
  logic [W-1:0] ma [N][N];
  logic [W-1:0] mb [N][N];
  int phase = 0;
  int mt    = 0;
  int done_count = 0;
  bit cmp_en = 0;

  function automatic logic [N-1:0] exp_valid();
    logic [N-1:0] v = '0;
    for (int i = 0; i < N; i++)
      if (phase == 1 && mt >= i && mt < i + N) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [N*W-1:0] exp_adata();
    logic [N*W-1:0] d = '0;
    for (int i = 0; i < N; i++)
      if (phase == 1 && mt >= i && mt < i + N) d[i*W +: W] = ma[i][mt-i];
    return d;
  endfunction

  function automatic logic [N*W-1:0] exp_bdata();
    logic [N*W-1:0] d = '0;
    for (int j = 0; j < N; j++)
      if (phase == 1 && mt >= j && mt < j + N) d[j*W +: W] = mb[mt-j][j];
    return d;
  endfunction

  // One clock edge: advance the model with the inputs present at the edge,
  // then move off the edge so the caller may change inputs.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          ma[r][c] = '0;
          mb[r][c] = '0;
        end
      phase = 0;
      mt    = 0;
    end else begin
      case (phase)
        0: begin
          if (start) begin
            phase = 1;
            mt    = 0;
          end else if (wr_en) begin
            if (wr_sel) mb[wr_row][wr_col] = wr_data;
            else        ma[wr_row][wr_col] = wr_data;
          end
        end
        1: begin
          if (mt == NSTEPS - 1) begin
            phase = 2;
            done_count++;
          end else begin
            mt++;
          end
        end
        default: begin
          if (start) begin
            phase = 1;
            mt    = 0;
          end else begin
            phase = 0;
          end
        end
      endcase
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy",    64'(busy),    64'(phase == 1));
      chk("done",    64'(done),    64'(phase == 2));
      chk("a_valid", 64'(a_valid), 64'(exp_valid()));
      chk("b_valid", 64'(b_valid), 64'(exp_valid()));
      chk("a_data",  64'(a_data),  64'(exp_adata()));
      chk("b_data",  64'(b_data),  64'(exp_bdata()));
    end
  end

  task automatic idle_inputs();
    reset = 1'b0; wr_en = 1'b0; wr_sel = 1'b0;
    wr_row = '0; wr_col = '0; wr_data = '0; start = 1'b0;
  endtask

  task automatic write_elem(input logic sel, input int r, input int c, input logic [W-1:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_row = IW'(r); wr_col = IW'(c); wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int dc0;
    idle_inputs();
    #2;

    // ---- reset with random activity ----
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wr_en = 1'($urandom); wr_sel = 1'($urandom);
      wr_row = IW'($urandom); wr_col = IW'($urandom);
      wr_data = W'($urandom); start = 1'($urandom);
      tick();
      cmp_en = 1;
    end
    idle_inputs();
    chk("rst_busy",    64'(busy),    64'(0));
    chk("rst_done",    64'(done),    64'(0));
    chk("rst_a_valid", 64'(a_valid), 64'(0));
    chk("rst_b_data",  64'(b_data),  64'(0));
    // A stream straight after reset must carry only zero data.
    start = 1'b1; tick(); start = 1'b0;
    run_cycles(NSTEPS + 2);

    // ---- full stream with known pattern ----
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        write_elem(1'b0, i, k, W'(16*i + k));
        write_elem(1'b1, i, k, W'(8'h80 + 16*i + k));
      end
    dc0 = done_count;
    start = 1'b1; tick(); start = 1'b0;                 // edge k, t=0
    chk("t0_a_valid", 64'(a_valid), 64'(4'b0001));
    chk("t0_a_lane0", 64'(a_data[7:0]), 64'(8'h00));
    chk("t0_b_lane0", 64'(b_data[7:0]), 64'(8'h80));
    tick(); tick();                                     // t=2
    write_elem(1'b0, 0, 3, 8'hFF);                      // t=3, write dropped
    chk("t3_a_valid", 64'(a_valid), 64'(4'b1111));
    chk("t3_a_lane0", 64'(a_data[7:0]), 64'(8'h03));
    chk("t3_a_lane3", 64'(a_data[31:24]), 64'(8'h30));
    chk("t3_b_lane3", 64'(b_data[31:24]), 64'(8'h83));
    tick();                                             // t=4
    start = 1'b1; tick(); start = 1'b0;                 // t=5, start ignored
    tick();                                             // t=6
    chk("t6_a_valid", 64'(a_valid), 64'(4'b1000));
    chk("t6_a_lane3", 64'(a_data[31:24]), 64'(8'h33));
    chk("t6_b_lane3", 64'(b_data[31:24]), 64'(8'hB3));
    run_cycles(3);                                      // t=9
    chk("t9_busy",    64'(busy),    64'(1));
    chk("t9_a_valid", 64'(a_valid), 64'(0));
    tick();                                             // edge k+10
    chk("k10_done", 64'(done), 64'(1));
    chk("k10_busy", 64'(busy), 64'(0));
    chk("one_done", 64'(done_count - dc0), 64'(1));
    start = 1'b1; tick(); start = 1'b0;                 // edge k+11, new t=0
    chk("k11_a_valid", 64'(a_valid), 64'(4'b0001));
    chk("k11_busy",    64'(busy),    64'(1));
    run_cycles(3);                                      // t=3 of second stream
    chk("s2_t3_a_lane0", 64'(a_data[7:0]), 64'(8'h03));
    run_cycles(2);                                      // t=5
    // ---- reset mid-stream ----
    dc0 = done_count;
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mid_rst_busy",    64'(busy),    64'(0));
    chk("mid_rst_a_valid", 64'(a_valid), 64'(0));
    chk("mid_rst_a_data",  64'(a_data),  64'(0));
    run_cycles(8);
    chk("mid_rst_no_done", 64'(done_count - dc0), 64'(0));
    start = 1'b1; tick(); start = 1'b0;
    chk("rs_t0_a_valid", 64'(a_valid), 64'(4'b0001));
    tick(); tick(); tick();
    chk("rs_t3_a_data", 64'(a_data), 64'(0));
    run_cycles(NSTEPS + 1);

    // ---- simultaneous start and write ----
    write_elem(1'b1, 0, 0, 8'h22);
    wr_en = 1'b1; wr_sel = 1'b1; wr_row = '0; wr_col = '0; wr_data = 8'h55;
    start = 1'b1; tick(); idle_inputs();
    chk("sim_b_lane0", 64'(b_data[7:0]), 64'(8'h22));
    run_cycles(NSTEPS + 1);
    start = 1'b1; tick(); start = 1'b0;
    chk("sim_b_kept", 64'(b_data[7:0]), 64'(8'h22));
    run_cycles(NSTEPS + 1);

    // ---- randomized traffic ----
    for (int c = 0; c < 4000; c++) begin
      reset   = ($urandom_range(0, 399) == 0);
      wr_en   = 1'($urandom);
      wr_sel  = 1'($urandom);
      wr_row  = IW'($urandom);
      wr_col  = IW'($urandom);
      wr_data = W'($urandom);
      start   = ($urandom_range(0, 11) == 0);
      tick();
    end
    idle_inputs();
    run_cycles(NSTEPS + 3);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
